vau_op_sequencer: RTL and testbench

- Sequences one vector operation at a time through the 4-lane FP32 vector ALU (`Top_Module_4_ALU`).
- Accepts a command over a valid/ready interface: opcode plus two 128-bit operands.
- Serially loads operand A and then operand B into the ALU through its shared operand port, issues the operation, waits a fixed latency, and returns the 128-bit result with per-lane exception, overflow and underflow flags over a valid/ready response interface.
- Sits between the Caravel-facing control logic (LA/Wishbone glue) and the ALU.

---
 rtl/vau_pkg.sv | 26 ++
 rtl/vau_seq_lat_timer.sv | 29 ++
 rtl/vau_op_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_vau_op_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vau_pkg.sv
// Shared types and constants for the vector-ALU operation sequencer.
package vau_pkg;

  localparam int unsigned VAU_LANES  = 4;
  localparam int unsigned VAU_LANE_W = 32;
  localparam int unsigned VAU_DATA_W = VAU_LANES * VAU_LANE_W;
  localparam int unsigned VAU_OP_W   = 4;

  localparam logic [VAU_OP_W-1:0] VAU_OP_ADD = 4'h0;
  localparam logic [VAU_OP_W-1:0] VAU_OP_SUB = 4'h1;
  localparam logic [VAU_OP_W-1:0] VAU_OP_MUL = 4'h2;
  localparam logic [VAU_OP_W-1:0] VAU_OP_DIV = 4'h3;

  // One flag bit per lane.
  typedef logic [VAU_LANES-1:0] vau_flags_t;

  typedef enum logic [2:0] {
    VAU_IDLE   = 3'd0,
    VAU_LOAD_A = 3'd1,
    VAU_LOAD_B = 3'd2,
    VAU_EXEC   = 3'd3,
    VAU_WAIT   = 3'd4,
    VAU_DONE   = 3'd5
  } vau_seq_state_t;

endpackage

// File: rtl/vau_seq_lat_timer.sv
// Latency down-counter: loads LATENCY-1, counts down while enabled, flags zero.
module vau_seq_lat_timer #(
  parameter int unsigned LATENCY = 3
) (
  input  logic clk,
  input  logic i_rst,
  input  logic load,
  input  logic en,
  output logic done_c
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [CNT_W-1:0] cnt_q;

  // Counter register; saturates at zero.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CNT_W'(LATENCY - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/vau_op_sequencer.sv
// Sequences one command through the 4-lane FP32 vector ALU: load A, load B,
// issue, wait fixed latency, return result and per-lane flags.
// Optional sticky flag accumulator: define VAU_SEQ_STICKY_FLAGS_EN.
module vau_op_sequencer
  import vau_pkg::*;
#(
  parameter int unsigned LANES       = VAU_LANES,
  parameter int unsigned LANE_W      = VAU_LANE_W,
  parameter int unsigned ALU_LATENCY = 3,
  parameter int unsigned NUM_OPS     = 8
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [3:0]                cmd_op,
  input  logic [LANES*LANE_W-1:0]   cmd_a,
  input  logic [LANES*LANE_W-1:0]   cmd_b,
  output logic                      alu_ce,
  output logic                      alu_operand_sel,
  output logic [3:0]                alu_op,
  output logic [LANES*LANE_W-1:0]   alu_operand,
  input  logic [LANES*LANE_W-1:0]   alu_result,
  input  logic [LANES-1:0]          alu_exception,
  input  logic [LANES-1:0]          alu_overflow,
  input  logic [LANES-1:0]          alu_underflow,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [LANES*LANE_W-1:0]   rsp_data,
  output logic [LANES-1:0]          rsp_exc,
  output logic [LANES-1:0]          rsp_ovf,
  output logic [LANES-1:0]          rsp_unf,
  output logic                      rsp_err,
  output logic                      busy
`ifdef VAU_SEQ_STICKY_FLAGS_EN
  ,
  output logic [3*LANES-1:0]        sticky_flags,
  input  logic                      sticky_clr
`endif
);

  localparam int unsigned DATA_W = LANES * LANE_W;

  vau_seq_state_t state_q, state_d;

  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;

  logic              accept_c;
  logic              op_legal_c;
  logic              cap_alu_c;
  logic              cap_err_c;
  logic              timer_done_c;

  logic              cmd_ready_d, alu_ce_d, alu_sel_d, rsp_valid_d, busy_d;
  logic [3:0]        alu_op_d;
  logic [DATA_W-1:0] alu_operand_d;

  assign op_legal_c = (32'(cmd_op) < NUM_OPS);

  // Latency counter, loaded on issue and run during WAIT.
  vau_seq_lat_timer #(
    .LATENCY (ALU_LATENCY)
  ) u_lat_timer (
    .clk    (clk),
    .i_rst  (i_rst),
    .load   (state_q == VAU_EXEC),
    .en     (state_q == VAU_WAIT),
    .done_c (timer_done_c)
  );

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    accept_c      = 1'b0;
    cap_alu_c     = 1'b0;
    cap_err_c     = 1'b0;
    cmd_ready_d   = 1'b0;
    alu_ce_d      = 1'b0;
    alu_sel_d     = 1'b0;
    alu_op_d      = '0;
    alu_operand_d = '0;
    rsp_valid_d   = 1'b0;
    busy_d        = 1'b0;

    case (state_q)
      VAU_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept_c = 1'b1;
          if (op_legal_c) begin
            state_d = VAU_LOAD_A;
          end else begin
            state_d   = VAU_DONE;
            cap_err_c = 1'b1;
          end
        end
      end
      VAU_LOAD_A: state_d = VAU_LOAD_B;
      VAU_LOAD_B: state_d = VAU_EXEC;
      VAU_EXEC:   state_d = VAU_WAIT;
      VAU_WAIT: begin
        if (timer_done_c) begin
          state_d   = VAU_DONE;
          cap_alu_c = 1'b1;
        end
      end
      VAU_DONE: begin
        if (rsp_ready) state_d = VAU_IDLE;
      end
      default: state_d = VAU_IDLE;
    endcase

    busy_d = (state_d != VAU_IDLE);
    case (state_d)
      VAU_IDLE: cmd_ready_d = 1'b1;
      VAU_LOAD_A: begin
        alu_ce_d      = 1'b1;
        alu_operand_d = accept_c ? cmd_a : a_q;
      end
      VAU_LOAD_B: begin
        alu_ce_d      = 1'b1;
        alu_sel_d     = 1'b1;
        alu_operand_d = b_q;
      end
      VAU_EXEC, VAU_WAIT: begin
        alu_ce_d = 1'b1;
        alu_op_d = op_q;
      end
      VAU_DONE: rsp_valid_d = 1'b1;
      default: ;
    endcase
  end

  // State and control output registers.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q         <= VAU_IDLE;
      cmd_ready       <= 1'b0;
      alu_ce          <= 1'b0;
      alu_operand_sel <= 1'b0;
      alu_op          <= '0;
      alu_operand     <= '0;
      rsp_valid       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state_q         <= state_d;
      cmd_ready       <= cmd_ready_d;
      alu_ce          <= alu_ce_d;
      alu_operand_sel <= alu_sel_d;
      alu_op          <= alu_op_d;
      alu_operand     <= alu_operand_d;
      rsp_valid       <= rsp_valid_d;
      busy            <= busy_d;
    end
  end

  // Command latch, loaded on accept.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept_c) begin
      op_q <= cmd_op;
      a_q  <= cmd_a;
      b_q  <= cmd_b;
    end
  end

  // Response registers: ALU capture or illegal-opcode error; held otherwise.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_data <= '0;
      rsp_exc  <= '0;
      rsp_ovf  <= '0;
      rsp_unf  <= '0;
      rsp_err  <= 1'b0;
    end else if (cap_alu_c) begin
      rsp_data <= alu_result;
      rsp_exc  <= alu_exception;
      rsp_ovf  <= alu_overflow;
      rsp_unf  <= alu_underflow;
      rsp_err  <= 1'b0;
    end else if (cap_err_c) begin
      rsp_data <= '0;
      rsp_exc  <= '0;
      rsp_ovf  <= '0;
      rsp_unf  <= '0;
      rsp_err  <= 1'b1;
    end
  end

`ifdef VAU_SEQ_STICKY_FLAGS_EN
  // Sticky flag accumulator; a clear beats a simultaneous capture.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      sticky_flags <= '0;
    end else if (sticky_clr) begin
      sticky_flags <= '0;
    end else if (cap_alu_c) begin
      sticky_flags <= sticky_flags | {alu_underflow, alu_overflow, alu_exception};
    end
  end
`endif

endmodule

// File: tb/tb_vau_op_sequencer.sv
// Directed self-checking bench for vau_op_sequencer; the bench plays the ALU.
`timescale 1ns/1ps
module tb_vau_op_sequencer;

  localparam int unsigned LAT = 3;
  localparam logic [127:0] JUNK = 128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678;
  localparam logic [127:0] A_ONE  = {4{32'h3F80_0000}};
  localparam logic [127:0] B_TWO  = {4{32'h4000_0000}};
  localparam logic [127:0] R_THR  = {4{32'h4040_0000}};
  localparam logic [127:0] A_MAX  = {4{32'h7F7F_FFFF}};
  localparam logic [127:0] R_INF  = {4{32'h7F80_0000}};

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_op = '0;
  logic [127:0] cmd_a = '0, cmd_b = '0;
  logic         alu_ce, alu_operand_sel;
  logic [3:0]   alu_op;
  logic [127:0] alu_operand;
  logic [127:0] alu_result = JUNK;
  logic [3:0]   alu_exception = 4'hA, alu_overflow = 4'h5, alu_underflow = 4'hC;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic [3:0]   rsp_exc, rsp_ovf, rsp_unf;
  logic         rsp_err, busy;
`ifdef VAU_SEQ_STICKY_FLAGS_EN
  logic [11:0]  sticky_flags;
  logic         sticky_clr = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vau_op_sequencer #(
    .LANES(4), .LANE_W(32), .ALU_LATENCY(LAT), .NUM_OPS(8)
  ) dut (
    .clk(clk), .i_rst(i_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_ce(alu_ce), .alu_operand_sel(alu_operand_sel), .alu_op(alu_op),
    .alu_operand(alu_operand), .alu_result(alu_result),
    .alu_exception(alu_exception), .alu_overflow(alu_overflow),
    .alu_underflow(alu_underflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_exc(rsp_exc), .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf), .rsp_err(rsp_err),
    .busy(busy)
`ifdef VAU_SEQ_STICKY_FLAGS_EN
    , .sticky_flags(sticky_flags), .sticky_clr(sticky_clr)
`endif
  );

  task automatic alu_junk();
    alu_result = JUNK; alu_exception = 4'hA; alu_overflow = 4'h5; alu_underflow = 4'hC;
  endtask

  // Issue one command and act as the ALU; returns observations, no checking.
  task automatic run_txn(input logic [3:0] op, input logic [127:0] a, input logic [127:0] b,
                         input logic [127:0] res, input logic [3:0] exc, input logic [3:0] ovf,
                         input logic [3:0] unf, input int clr_at,
                         output int lat, output int ce_cnt,
                         output logic [127:0] seen_a, output logic [127:0] seen_b,
                         output logic seen_sel_a, output logic seen_sel_b,
                         output logic [3:0] seen_op_a, output logic [3:0] seen_op_x);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 4'h1; cmd_a = JUNK; cmd_b = ~JUNK;
    lat = -1; ce_cnt = 0;
    seen_a = 'x; seen_b = 'x; seen_sel_a = 1'bx; seen_sel_b = 1'bx; seen_op_a = 'x; seen_op_x = 'x;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = c; break; end
      if (alu_ce) ce_cnt++;
      if (c == 1) begin seen_a = alu_operand; seen_sel_a = alu_operand_sel; seen_op_a = alu_op; end
      if (c == 2) begin seen_b = alu_operand; seen_sel_b = alu_operand_sel; end
      if (c == 3) seen_op_x = alu_op;
`ifdef VAU_SEQ_STICKY_FLAGS_EN
      sticky_clr = (c == clr_at);
`endif
      if (c == int'(LAT) + 3) begin
        alu_result = res; alu_exception = exc; alu_overflow = ovf; alu_underflow = unf;
      end else begin
        alu_junk();
      end
    end
    alu_junk();
`ifdef VAU_SEQ_STICKY_FLAGS_EN
    sticky_clr = 1'b0;
`else
    if (clr_at < 0) lat = lat;
`endif
  endtask

  // Response handshake starting at the current negedge.
  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready); end
    checks++; if ({alu_ce, alu_operand_sel, alu_op, busy, rsp_valid, rsp_err} !== 9'd0) begin errors++; $display("FAIL rst_ctrl got %b exp 0", {alu_ce, alu_operand_sel, alu_op, busy, rsp_valid, rsp_err}); end
    checks++; if ({alu_operand, rsp_data, rsp_exc, rsp_ovf, rsp_unf} !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", {alu_operand, rsp_data}); end
`ifdef VAU_SEQ_STICKY_FLAGS_EN
    checks++; if (sticky_flags !== 12'h000) begin errors++; $display("FAIL rst_sticky got %h exp 000", sticky_flags); end
`endif
    i_rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_add();
    int lat, ce; logic [127:0] sa, sb; logic ssa, ssb; logic [3:0] soa, sox;
    run_txn(4'h0, A_ONE, B_TWO, R_THR, 4'h0, 4'h0, 4'h0, -1, lat, ce, sa, sb, ssa, ssb, soa, sox);
    checks++; if (lat !== 7) begin errors++; $display("FAIL add_latency got %0d exp 7", lat); end
    checks++; if ({sa, ssa, soa} !== {A_ONE, 1'b0, 4'h0}) begin errors++; $display("FAIL add_load_a got %h/%b/%h exp %h/0/0", sa, ssa, soa, A_ONE); end
    checks++; if ({sb, ssb} !== {B_TWO, 1'b1}) begin errors++; $display("FAIL add_load_b got %h/%b exp %h/1", sb, ssb, B_TWO); end
    checks++; if (ce !== 6) begin errors++; $display("FAIL add_ce_cycles got %0d exp 6", ce); end
    checks++; if (rsp_data !== R_THR) begin errors++; $display("FAIL add_data got %h exp %h", rsp_data, R_THR); end
    checks++; if ({rsp_exc, rsp_ovf, rsp_unf, rsp_err} !== 13'd0) begin errors++; $display("FAIL add_flags got %b exp 0", {rsp_exc, rsp_ovf, rsp_unf, rsp_err}); end
    checks++; if ({alu_ce, cmd_ready, busy} !== 3'b001) begin errors++; $display("FAIL add_done_ctrl got %b exp 001", {alu_ce, cmd_ready, busy}); end
    ack();
  endtask

  task automatic test_overflow();
    int lat, ce; logic [127:0] sa, sb; logic ssa, ssb; logic [3:0] soa, sox;
    @(negedge clk);
    run_txn(4'h2, A_MAX, B_TWO, R_INF, 4'h0, 4'hF, 4'h0, -1, lat, ce, sa, sb, ssa, ssb, soa, sox);
    checks++; if (sox !== 4'h2) begin errors++; $display("FAIL ovf_exec_op got %h exp 2", sox); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL ovf_latency got %0d exp 7", lat); end
    checks++; if ({rsp_data, rsp_ovf, rsp_exc, rsp_unf} !== {R_INF, 4'hF, 4'h0, 4'h0}) begin errors++; $display("FAIL ovf_rsp got %h ovf %h exp %h ovf f", rsp_data, rsp_ovf, R_INF); end
`ifdef VAU_SEQ_STICKY_FLAGS_EN
    checks++; if (sticky_flags !== 12'h0F0) begin errors++; $display("FAIL ovf_sticky got %h exp 0f0", sticky_flags); end
`endif
    ack();
  endtask

  task automatic test_illegal();
    int lat, ce; logic [127:0] sa, sb; logic ssa, ssb; logic [3:0] soa, sox;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ill_ready got %b exp 1", cmd_ready); end
    run_txn(4'hF, A_ONE, B_TWO, R_THR, 4'hF, 4'hF, 4'hF, -1, lat, ce, sa, sb, ssa, ssb, soa, sox);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ill_latency got %0d exp 1", lat); end
    checks++; if (ce !== 0 || alu_ce !== 1'b0) begin errors++; $display("FAIL ill_alu_ce got %0d exp 0", ce); end
    checks++; if ({rsp_err, rsp_data, rsp_exc, rsp_ovf, rsp_unf} !== {1'b1, 140'd0}) begin errors++; $display("FAIL ill_rsp got err %b data %h exp err 1 data 0", rsp_err, rsp_data); end
`ifdef VAU_SEQ_STICKY_FLAGS_EN
    checks++; if (sticky_flags !== 12'h0F0) begin errors++; $display("FAIL ill_sticky got %h exp 0f0", sticky_flags); end
`endif
    ack();
  endtask

  task automatic test_backpressure();
    int lat, ce; int bad; logic [127:0] sa, sb; logic ssa, ssb; logic [3:0] soa, sox;
    @(negedge clk);
    run_txn(4'h0, A_ONE, B_TWO, R_THR, 4'h1, 4'h0, 4'h8, -1, lat, ce, sa, sb, ssa, ssb, soa, sox);
    bad = 0;
    cmd_valid = 1'b1; cmd_op = 4'h3;
    for (int i = 0; i < 10; i++) begin
      alu_result = JUNK ^ 128'(i);
      @(negedge clk);
      if ({rsp_valid, cmd_ready, rsp_data, rsp_exc, rsp_ovf, rsp_unf, rsp_err} !== {2'b10, R_THR, 4'h1, 4'h0, 4'h8, 1'b0}) bad++;
    end
    cmd_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
    ack();
    @(negedge clk);
    checks++; if ({cmd_ready, rsp_valid, busy} !== 3'b100) begin errors++; $display("FAIL bp_release got %b exp 100", {cmd_ready, rsp_valid, busy}); end
  endtask

  task automatic test_back_to_back();
    int lat, ce; logic [127:0] sa, sb; logic ssa, ssb; logic [3:0] soa, sox;
    run_txn(4'h1, B_TWO, A_ONE, A_ONE, 4'h0, 4'h0, 4'h0, -1, lat, ce, sa, sb, ssa, ssb, soa, sox);
    ack();
    run_txn(4'h0, A_ONE, A_ONE, B_TWO, 4'h0, 4'h0, 4'h0, -1, lat, ce, sa, sb, ssa, ssb, soa, sox);
    checks++; if (lat !== 7 || rsp_data !== B_TWO) begin errors++; $display("FAIL b2b_second got lat %0d data %h exp 7 %h", lat, rsp_data, B_TWO); end
    ack();
  endtask

  task automatic test_sticky_collide();
`ifdef VAU_SEQ_STICKY_FLAGS_EN
    int lat, ce; logic [127:0] sa, sb; logic ssa, ssb; logic [3:0] soa, sox;
    @(negedge clk);
    run_txn(4'h2, A_MAX, B_TWO, R_INF, 4'h0, 4'hF, 4'h0, int'(LAT) + 3, lat, ce, sa, sb, ssa, ssb, soa, sox);
    checks++; if (sticky_flags !== 12'h000) begin errors++; $display("FAIL sticky_collide got %h exp 000", sticky_flags); end
    checks++; if (rsp_ovf !== 4'hF) begin errors++; $display("FAIL sticky_collide_rsp got %h exp f", rsp_ovf); end
    ack();
`endif
  endtask

  task automatic test_reset_mid();
    int lat, ce; logic [127:0] sa, sb; logic ssa, ssb; logic [3:0] soa, sox;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'h2; cmd_a = A_MAX; cmd_b = B_TWO;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if ({busy, alu_ce, alu_op} !== 6'b11_0010) begin errors++; $display("FAIL mid_in_wait got %b exp 110010", {busy, alu_ce, alu_op}); end
    i_rst = 1'b1; #1;
    checks++; if ({cmd_ready, busy, alu_ce, alu_operand_sel, alu_op, rsp_valid, rsp_err} !== 10'd0 || {alu_operand, rsp_data} !== '0) begin errors++; $display("FAIL mid_async_clear got %b exp 0", {cmd_ready, busy, alu_ce, alu_op, rsp_valid}); end
`ifdef VAU_SEQ_STICKY_FLAGS_EN
    checks++; if (sticky_flags !== 12'h000) begin errors++; $display("FAIL mid_sticky got %h exp 000", sticky_flags); end
`endif
    @(negedge clk);
    i_rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL mid_release got %b exp 10", {cmd_ready, rsp_valid}); end
    run_txn(4'h0, A_ONE, B_TWO, R_THR, 4'h0, 4'h0, 4'h0, -1, lat, ce, sa, sb, ssa, ssb, soa, sox);
    checks++; if (lat !== 7 || rsp_data !== R_THR || rsp_err !== 1'b0) begin errors++; $display("FAIL mid_add got lat %0d data %h exp 7 %h", lat, rsp_data, R_THR); end
    ack();
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_sticky_collide();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
